rbz_spi_frame_tx: RTL and testbench

SPI-mode-0 master that serialises one frame per request onto a 3-wire link (sclk/mosi/ss_n). This is the transmit end of raybox-zero's POV and register SPI receivers (pov_sclk/pov_mosi/pov_ss_n, reg_sclk/reg_mosi/reg_ss_n). It is used by a host-side controller or bench harness to push a 74-bit POV frame or a shorter register-write frame into raybox-zero. The block is write-only: there is no MISO path.

---
 rtl/rbz_spi_frame_tx.sv | 167 ++++++++++++++++
 tb/tb_rbz_spi_frame_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rbz_spi_frame_tx.sv
// SPI mode-0 write-only frame transmitter (sclk/mosi/ss_n), MSB-first from bit len-1.
// Optional abort input / aborted pulse enabled by defining RBZ_SPI_FRAME_TX_ABORT_EN.
module rbz_spi_frame_tx #(
    parameter int FRAME_W = 74,
    parameter int LEN_W   = 7,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    input  logic [LEN_W-1:0]   len,
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic               sclk,
    output logic               mosi,
    output logic               ss_n,
    output logic               busy,
    output logic               done
);

    localparam int                PH_W      = $clog2(CLK_DIV) + 1;
    localparam logic [LEN_W-1:0]  FRAME_LEN = LEN_W'(FRAME_W);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t             state_r, state_nx_s;
    logic [PH_W-1:0]    phase_r, phase_nx_s;
    logic [LEN_W-1:0]   bit_cnt_r, bit_cnt_nx_s;
    logic [FRAME_W-1:0] shift_r, shift_nx_s, shift_load_s;
    logic [LEN_W-1:0]   len_eff_s;
    logic               phase_end_s;
    logic               mosi_nx_s, done_nx_s;
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
    logic               abort_flag_r, abort_flag_nx_s, aborted_nx_s;
`endif

    // Clamp the requested length and left-align the payload so bit len-1 sits at the MSB.
    always_comb begin
        len_eff_s    = (len > FRAME_LEN) ? FRAME_LEN : len;
        shift_load_s = frame << (FRAME_LEN - len_eff_s);
        phase_end_s  = (phase_r == PH_LAST);
    end

    // Next-state logic; the last bit is detected with the counter still at 1.
    always_comb begin
        state_nx_s   = state_r;
        phase_nx_s   = '0;
        bit_cnt_nx_s = bit_cnt_r;
        shift_nx_s   = shift_r;
        mosi_nx_s    = mosi;
        done_nx_s    = 1'b0;
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
        abort_flag_nx_s = abort_flag_r;
        aborted_nx_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_nx_s   = LEAD;
                    bit_cnt_nx_s = len_eff_s;
                    shift_nx_s   = shift_load_s;
                    mosi_nx_s    = shift_load_s[FRAME_W-1];
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
                    abort_flag_nx_s = 1'b0;
`endif
                end else begin
                    mosi_nx_s = 1'b0;
                end
            end
            LEAD: begin
                if (phase_end_s) begin
                    state_nx_s = HIGH;
                end else begin
                    phase_nx_s = phase_r + PH_W'(1);
                end
            end
            HIGH: begin
                if (phase_end_s) begin
                    state_nx_s   = LOW;
                    bit_cnt_nx_s = bit_cnt_r - LEN_W'(1);
                    shift_nx_s   = shift_r << 1;
                    mosi_nx_s    = (bit_cnt_r != LEN_W'(1)) ? shift_r[FRAME_W-2] : 1'b0;
                end else begin
                    phase_nx_s = phase_r + PH_W'(1);
                end
            end
            LOW: begin
                if (phase_end_s) begin
                    state_nx_s = (bit_cnt_r != '0) ? HIGH : GAP;
                end else begin
                    phase_nx_s = phase_r + PH_W'(1);
                end
            end
            GAP: begin
                if (phase_end_s) begin
                    state_nx_s = IDLE;
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
                    done_nx_s    = ~abort_flag_r;
                    aborted_nx_s = abort_flag_r;
`else
                    done_nx_s    = 1'b1;
`endif
                end else begin
                    phase_nx_s = phase_r + PH_W'(1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                mosi_nx_s  = 1'b0;
            end
        endcase
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
        if (abort && ((state_r == LEAD) || (state_r == HIGH) || (state_r == LOW))) begin
            state_nx_s      = GAP;
            phase_nx_s      = '0;
            mosi_nx_s       = 1'b0;
            abort_flag_nx_s = 1'b1;
        end else begin
            abort_flag_nx_s = abort_flag_nx_s;
        end
`endif
    end

    // State, datapath and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            phase_r   <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            ss_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
            abort_flag_r <= 1'b0;
            aborted      <= 1'b0;
`endif
        end else begin
            state_r   <= state_nx_s;
            phase_r   <= phase_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            shift_r   <= shift_nx_s;
            sclk      <= (state_nx_s == HIGH);
            mosi      <= mosi_nx_s;
            ss_n      <= ~((state_nx_s == LEAD) || (state_nx_s == HIGH) || (state_nx_s == LOW));
            busy      <= (state_nx_s != IDLE);
            done      <= done_nx_s;
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
            abort_flag_r <= abort_flag_nx_s;
            aborted      <= aborted_nx_s;
`endif
        end
    end

endmodule

// File: tb/tb_rbz_spi_frame_tx.sv
// Directed self-checking bench for rbz_spi_frame_tx with a mode-0 slave capture model.
module tb_rbz_spi_frame_tx;

    localparam int FRAME_W = 74;
    localparam int LEN_W   = 7;
    localparam int CLK_DIV = 2;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic [FRAME_W-1:0] frame = '0;
    logic [LEN_W-1:0]   len   = '0;
    logic               sclk, mosi, ss_n, busy, done;
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
    logic               abort = 1'b0;
    logic               aborted;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    rbz_spi_frame_tx #(.FRAME_W(FRAME_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame(frame), .len(len),
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model and link monitor, sampled on the falling clk edge.
    int cyc = 0, fall_cyc = 0, done_cyc = 0, edge_cnt = 0, ss_low_cnt = 0;
    int done_cnt = 0, fall_cnt = 0, hi_run = 0, last_hi_run = 0, mosi_viol = 0, aborted_cnt = 0;
    logic [127:0] cap = '0;
    logic sclk_q = 1'b0, mosi_q = 1'b0, ss_q = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (ss_q && !ss_n) begin
            fall_cnt++;
            fall_cyc    = cyc;
            last_hi_run = hi_run;
            hi_run      = 0;
            edge_cnt    = 0;
            ss_low_cnt  = 0;
            cap         = '0;
        end
        if (ss_n) hi_run++;
        else      ss_low_cnt++;
        if (sclk && !sclk_q) begin
            edge_cnt++;
            cap = {cap[126:0], mosi};
        end
        if (sclk && sclk_q && (mosi != mosi_q)) mosi_viol++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
        if (aborted) aborted_cnt++;
`endif
        sclk_q = sclk;
        mosi_q = mosi;
        ss_q   = ss_n;
    end

    task automatic start_frame(input logic [FRAME_W-1:0] f, input logic [LEN_W-1:0] l);
        @(posedge clk);
        #1;
        frame = f;
        len   = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns in the done cycle, after the monitor has sampled it.
    task automatic wait_done(input string tag);
        bit found = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        #1;
        check_eq({tag, "_done_seen"}, 128'(found), 128'd1);
        check_eq({tag, "_busy_at_done"}, 128'(busy), 128'd0);
    endtask

    logic [95:0]        r96;
    logic [FRAME_W-1:0] f74;
    int                 fc, dc, n_wait;

    initial begin
        // Reset values and quiet idle.
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_sclk", 128'(sclk), 128'd0);
        check_eq("rst_ss_n", 128'(ss_n), 128'd1);
        check_eq("rst_mosi", 128'(mosi), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_done", 128'(done), 128'd0);
        rst_n = 1'b1;
        fc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sclk || !ss_n || mosi || busy || done) fc++;
        end
        check_eq("idle_quiet", 128'(fc), 128'd0);

        // 0xA5, 8 bits.
        done_cnt = 0;
        start_frame(FRAME_W'(8'hA5), 7'd8);
        wait_done("a5");
        check_eq("a5_bits", cap, 128'hA5);
        check_eq("a5_edges", 128'(edge_cnt), 128'd8);
        check_eq("a5_ss_low", 128'(ss_low_cnt), 128'd34);
        check_eq("a5_done_lat", 128'(done_cyc - fall_cyc), 128'd36);
        repeat (5) @(negedge clk);
        check_eq("a5_done_once", 128'(done_cnt), 128'd1);

        // Full-length frame, then a back-to-back start in the done cycle.
        r96 = {$urandom(), $urandom(), $urandom()};
        f74 = r96[73:0];
        start_frame(f74, 7'd74);
        wait_done("f74");
        check_eq("f74_bits", cap, 128'(f74));
        check_eq("f74_edges", 128'(edge_cnt), 128'd74);
        frame = FRAME_W'(4'h9);
        len   = 7'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b");
        check_eq("b2b_bits", cap, 128'h9);
        check_eq("b2b_edges", 128'(edge_cnt), 128'd4);
        // GAP (CLK_DIV cycles) plus the done cycle in which the next start is taken.
        check_eq("b2b_ss_high", 128'(last_hi_run), 128'(CLK_DIV + 1));

        // Start while busy is ignored; frame/len changes do not disturb the frame.
        done_cnt = 0;
        start_frame(FRAME_W'(8'hC3), 7'd8);
        repeat (10) @(posedge clk);
        #1;
        frame = '1;
        len   = 7'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("c3");
        check_eq("c3_bits", cap, 128'hC3);
        check_eq("c3_edges", 128'(edge_cnt), 128'd8);
        repeat (20) @(negedge clk);
        check_eq("c3_no_requeue", 128'(done_cnt), 128'd1);

        // len==0 does nothing.
        fc = fall_cnt;
        dc = done_cnt;
        start_frame(FRAME_W'(8'hFF), 7'd0);
        repeat (20) @(negedge clk);
        #1;
        check_eq("len0_no_ss", 128'(fall_cnt - fc), 128'd0);
        check_eq("len0_no_done", 128'(done_cnt - dc), 128'd0);
        check_eq("len0_idle", 128'(busy), 128'd0);

        // len>FRAME_W clamps to FRAME_W.
        r96 = {$urandom(), $urandom(), $urandom()};
        f74 = r96[73:0];
        start_frame(f74, 7'd100);
        wait_done("clamp");
        check_eq("clamp_edges", 128'(edge_cnt), 128'd74);
        check_eq("clamp_bits", cap, 128'(f74));

        // Asynchronous reset in the 10th bit's HIGH phase.
        start_frame(FRAME_W'(16'hBEEF), 7'd16);
        fc = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (edge_cnt >= 10) begin
                fc = 1;
                break;
            end
        end
        check_eq("rst10_reached", 128'(fc), 128'd1);
        done_cnt = 0;
        rst_n = 1'b0;
        #1;
        check_eq("rst10_sclk", 128'(sclk), 128'd0);
        check_eq("rst10_ss_n", 128'(ss_n), 128'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("rst10_no_done", 128'(done_cnt), 128'd0);
        start_frame(FRAME_W'(8'h3C), 7'd8);
        wait_done("x3c");
        check_eq("x3c_bits", cap, 128'h3C);
        check_eq("x3c_edges", 128'(edge_cnt), 128'd8);

`ifdef RBZ_SPI_FRAME_TX_ABORT_EN
        // Abort during bit 3.
        done_cnt    = 0;
        aborted_cnt = 0;
        start_frame(FRAME_W'(8'hFF), 7'd8);
        fc = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (edge_cnt >= 3) begin
                fc = 1;
                break;
            end
        end
        check_eq("abort_reached", 128'(fc), 128'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_eq("abort_ss_n", 128'(ss_n), 128'd1);
        check_eq("abort_sclk", 128'(sclk), 128'd0);
        n_wait = 0;
        for (int n = 1; n < 20; n++) begin
            @(negedge clk);
            if (aborted) begin
                n_wait = n;
                break;
            end
        end
        check_eq("abort_lat", 128'(n_wait), 128'd3);
        repeat (5) @(negedge clk);
        check_eq("abort_pulse_once", 128'(aborted_cnt), 128'd1);
        check_eq("abort_no_done", 128'(done_cnt), 128'd0);
`endif

        check_eq("mosi_stable_high", 128'(mosi_viol), 128'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
